// File: rtl/seq_logic_unit.sv
// seq_logic_unit: bitwise logic unit with an optional accumulator operand,
//   feeding a 2-entry in-order output queue and a delivered-result counter.
// Latency: a result accepted on edge N is on o (out_valid=1) right after edge N.
// Backpressure: in_ready drops only when both queue entries are full. It is
//   decoded from registered state alone, so there is no out_ready -> in_ready path.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   a, b, op, acc      - operands, operation select, accumulator-as-A select
//   in_valid, in_ready - input handshake
//   o, out_valid, out_ready - output handshake, o is the queue head
//   count              - results delivered since reset, wraps modulo 2^CNT_W
module seq_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] head, head_nxt;
  logic [WIDTH-1:0] skid, skid_nxt;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] res;
  logic             in_xfer;
  logic             out_xfer;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign o         = head;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Operand A comes from the accumulator when requested, which lets
  // consecutive accepted inputs chain with no bubble.
  always_comb begin
    opnd_a = acc ? acc_r : a;
    res    = '0;
    case (op)
      3'd0:    res = opnd_a & b;
      3'd1:    res = opnd_a | b;
      3'd2:    res = ~(opnd_a & b);
      3'd3:    res = ~(opnd_a | b);
      3'd4:    res = opnd_a ^ b;
      3'd5:    res = ~(opnd_a ^ b);
      3'd6:    res = ~opnd_a;
      default: res = ~b;
    endcase
  end

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = ONE;
          head_nxt  = res;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          // Head leaves and is replaced in the same edge; depth unchanged.
          head_nxt = res;
        end else if (in_xfer) begin
          state_nxt = TWO;
          skid_nxt  = res;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_nxt = ONE;
          head_nxt  = skid;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
      acc_r <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      skid  <= skid_nxt;
      if (in_xfer)  acc_r <= res;
      if (out_xfer) count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_logic_unit.sv
module tb_seq_logic_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic       acc = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [7:0]  o;
  logic [15:0] count;
  logic        in_ready4, out_valid4;
  logic [7:0]  o4;
  logic [3:0]  count4;

  int passed = 0;
  int total  = 0;

  // Reference model: FIFO of results, accumulator value, delivered count.
  logic [7:0] mq[$];
  logic [7:0] macc;
  int         mcount;

  always #5 clk = ~clk;

  seq_logic_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .acc(acc),
    .in_valid(in_valid), .in_ready(in_ready), .o(o), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  seq_logic_unit #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .acc(acc),
    .in_valid(in_valid), .in_ready(in_ready4), .o(o4), .out_valid(out_valid4),
    .out_ready(out_ready), .count(count4)
  );

  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                         input logic [2:0] k);
    case (k)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~(x & y);
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return ~y;
    endcase
  endfunction

  function automatic logic [7:0] mhead();
    return (mq.size() > 0) ? mq[0] : 8'h00;
  endfunction

  // Drive one cycle of inputs, advance the model across the rising edge,
  // and return at the following falling edge where outputs are sampled.
  task automatic drive(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] iop, input logic iacc, input logic ordy);
    logic       can_in, can_out;
    logic [7:0] r;
    in_valid = iv; a = ia; b = ib; op = iop; acc = iacc; out_ready = ordy;
    can_in  = (mq.size() < 2);
    can_out = (mq.size() > 0);
    r = ref_op(iacc ? macc : ia, ib, iop);
    @(posedge clk);
    if (can_out && ordy) begin
      void'(mq.pop_front());
      mcount++;
    end
    if (can_in && iv) begin
      mq.push_back(r);
      macc = r;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); macc = '0; mcount = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (o !== 8'h00) $display("FAIL reset_o got %h want 00", o); else passed++;
    total++; if (count !== 16'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    rst = 1'b0;
    mq.delete(); macc = '0; mcount = 0;
  endtask

  task automatic test_ops();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'h33};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'hF0, 8'hCC, 3'(k), 1'b0, 1'b1);
      total++;
      if (o !== exp_tab[k] || out_valid !== 1'b1)
        $display("FAIL ops_op%0d got o=%h vld=%b want o=%h vld=1", k, o, out_valid, exp_tab[k]);
      else passed++;
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    total++; if (count !== 16'd8) $display("FAIL ops_count got %0d want 8", count); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL ops_drained got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_chain();
    logic [7:0] bs [3];
    logic [7:0] exp_tab [3];
    bs = '{8'h00, 8'hFF, 8'h0F};
    exp_tab = '{8'h0F, 8'hF0, 8'hFF};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, (k == 0) ? 8'h0F : 8'hA5, bs[k], 3'd4, (k != 0), 1'b1);
      total++;
      if (o !== exp_tab[k]) $display("FAIL chain_%0d got %h want %h", k, o, exp_tab[k]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] seen[$];
    do_reset();
    drive(1'b1, 8'h11, 8'hFF, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 8'hFF, 3'd0, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got %b want 0", in_ready); else passed++;
    drive(1'b1, 8'h33, 8'hFF, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 8'hFF, 3'd0, 1'b0, 1'b0);
    total++; if (o !== 8'h11 || in_ready !== 1'b0)
      $display("FAIL bp_hold got o=%h rdy=%b want o=11 rdy=0", o, in_ready); else passed++;
    // Keep offering the third input with out_ready high until the queue drains.
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen.push_back(o);
      drive((k < 2), 8'h33, 8'hFF, 3'd0, 1'b0, 1'b1);
    end
    total++;
    if (seen.size() != 3 || seen[0] !== 8'h11 || seen[1] !== 8'h22 || seen[2] !== 8'h33)
      $display("FAIL bp_order got n=%0d want 11,22,33 in order", seen.size());
    else passed++;
    total++; if (count !== 16'd3) $display("FAIL bp_count got %0d want 3", count); else passed++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    do_reset();
    drive(1'b1, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(k * 7), 8'(k * 13 + 1), 3'(k), 1'(k[0]), 1'b1);
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || o !== mhead()) bad++;
    end
    total++; if (bad != 0) $display("FAIL b2b_steady got %0d bad cycles want 0", bad); else passed++;
    total++; if (count !== 16'd10) $display("FAIL b2b_count got %0d want 10", count); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 8'h33, 8'h00, 3'd1, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    drive(1'b1, 8'h44, 8'h00, 3'd1, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 8'h00, 3'd1, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0 || count !== 16'd1)
      $display("FAIL ar_setup got rdy=%b cnt=%0d want rdy=0 cnt=1", in_ready, count); else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 16'd0 || o !== 8'h00)
      $display("FAIL ar_async got vld=%b rdy=%b cnt=%0d o=%h want 0 1 0 00", out_valid, in_ready, count, o);
    else passed++;
    #1 rst = 1'b0;
    mq.delete(); macc = '0; mcount = 0;
    drive(1'b1, 8'hFF, 8'h5A, 3'd1, 1'b1, 1'b0);
    total++; if (o !== 8'h5A || out_valid !== 1'b1)
      $display("FAIL ar_after got o=%h vld=%b want 5A 1", o, out_valid); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 17; k++) drive(1'b1, 8'(k), 8'h0F, 3'd4, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    total++; if (count4 !== 4'd1) $display("FAIL wrap_cnt4 got %0d want 1", count4); else passed++;
    total++; if (count !== 16'd17) $display("FAIL wrap_cnt16 got %0d want 17", count); else passed++;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom_range(0, 2) != 0));
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          (mq.size() > 0 && o !== mq[0]) || count !== 16'(mcount) ||
          out_valid4 !== out_valid || in_ready4 !== (mq.size() < 2) ||
          (mq.size() > 0 && o4 !== mq[0]) || count4 !== 4'(mcount)) begin
        if (bad < 5)
          $display("FAIL rand_cycle%0d got o=%h vld=%b rdy=%b cnt=%0d want o=%h vld=%b rdy=%b cnt=%0d",
                   k, o, out_valid, in_ready, count, mhead(), (mq.size() > 0), (mq.size() < 2), mcount);
        bad++;
      end
    end
    total++; if (bad != 0) $display("FAIL rand_total got %0d bad cycles want 0", bad); else passed++;
    total++; if (mcount < 100) $display("FAIL rand_activity got %0d deliveries want >=100", mcount); else passed++;
  endtask

  initial begin
    macc = '0; mcount = 0;
    test_reset();
    test_ops();
    test_chain();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
